// File: rtl/lfsr_pattern_gen.sv
// Fibonacci-style LFSR pattern generator with valid/ready output and run control.
// Optional macro LFSR_SEED_RESTORE_EN: reload the seed on entering DONE so runs replay.
module lfsr_pattern_gen #(
   parameter int                    DATA_WIDTH = 54,
   parameter int                    CNT_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] POLY       = 54'h30000000030000
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_seed_vld,
   input  logic [DATA_WIDTH-1:0] i_seed_data,
   input  logic                  i_start,
   input  logic [CNT_WIDTH-1:0]  i_num_patterns,
   input  logic                  i_stop,
   input  logic                  i_rdy,
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_busy,
   output logic                  o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [DATA_WIDTH-1:0] seed_q, seed_d;
   logic [CNT_WIDTH-1:0]  rem_q, rem_d;
   logic [DATA_WIDTH-1:0] lfsr_nx;
   logic [DATA_WIDTH-1:0] seed_fix;
   logic                  xfer;

   assign lfsr_nx  = {lfsr_q[DATA_WIDTH-2:0], ^(lfsr_q & POLY)};
   // An all-zero LFSR would lock up, so a zero seed becomes 1
   assign seed_fix = (i_seed_data == '0) ? ONE : i_seed_data;
   assign xfer     = (state_q == RUN) && i_rdy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         lfsr_q  <= ONE;
         seed_q  <= ONE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         seed_q  <= seed_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      seed_d  = seed_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (i_seed_vld) begin
               lfsr_d = seed_fix;
               seed_d = seed_fix;
            end
            if (i_start) begin
               rem_d   = i_num_patterns;
               state_d = (i_num_patterns != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (xfer) begin
               lfsr_d = lfsr_nx;
               rem_d  = rem_q - CNT_ONE;
            end
            if ((xfer && rem_q == CNT_ONE) || i_stop)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef LFSR_SEED_RESTORE_EN
      // seed_d already carries a same-cycle seed load
      if (state_d == DONE && state_q != DONE)
         lfsr_d = seed_d;
`else
`endif
   end

   assign o_vld  = (state_q == RUN);
   assign o_busy = (state_q == RUN);
   assign o_done = (state_q == DONE);
   assign o_data = lfsr_q;

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Directed bench for lfsr_pattern_gen: vector table plus
// hand-written stall, stop, multi-run and reset sequences.
module tb_lfsr_pattern_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_vld;
   logic [53:0] seed_data;
   logic        start;
   logic [15:0] num;
   logic        stop;
   logic        rdy;
   logic        vld;
   logic [53:0] data;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lfsr_pattern_gen dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_seed_vld     (seed_vld),
      .i_seed_data    (seed_data),
      .i_start        (start),
      .i_num_patterns (num),
      .i_stop         (stop),
      .i_rdy          (rdy),
      .o_vld          (vld),
      .o_data         (data),
      .o_busy         (busy),
      .o_done         (done)
   );

   typedef struct {
      logic             ld;
      logic [53:0]      seed;
      logic [15:0]      n;
      logic [3:0][53:0] exp;
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue start (optionally with seed) and return at the first sample point
   task automatic go(input logic ld, input logic [53:0] sd,
                     input logic [15:0] n);
      @(negedge clk);
      seed_vld  = ld;
      seed_data = sd;
      start     = 1'b1;
      num       = n;
      @(negedge clk);
      seed_vld  = 1'b0;
      start     = 1'b0;
   endtask

   // Expect n transfers of first, first<<1, ... then an o_done pulse
   task automatic expect_run(input string nm, input int n,
                             input logic [53:0] first);
      logic [53:0] e;
      int          xf;
      bit          dn;
      e  = first;
      xf = 0;
      dn = 1'b0;
      for (int c = 0; c < 60 && !dn; c++) begin
         if (vld && rdy) begin
            chk(nm, data, e);
            e = e << 1;
            xf++;
         end
         if (done) dn = 1'b1;
         else @(negedge clk);
      end
      chk({nm, "_done"}, 64'(dn), 64'd1);
      chk({nm, "_n"}, 64'(xf), 64'(n));
   endtask

   initial begin
      int          xf;
      int          last;
      bit          dn;
      logic [53:0] e2;

      vt[0] = '{1'b1, 54'd1, 16'd3, {54'd0, 54'd4, 54'd2, 54'd1}};
      vt[1] = '{1'b1, 54'd0, 16'd2, {54'd0, 54'd0, 54'd2, 54'd1}};
      vt[2] = '{1'b1, 54'd0, 16'd0, {54'd0, 54'd0, 54'd0, 54'd0}};
      vt[3] = '{1'b1, 54'h20000000000000, 16'd3,
                {54'd0, 54'd2, 54'd1, 54'h20000000000000}};
      vt[4] = '{1'b1, 54'h10000, 16'd4,
                {54'h80006, 54'h40003, 54'h20001, 54'h10000}};
      vt[5] = '{1'b1, 54'd3, 16'd2, {54'd0, 54'd0, 54'd6, 54'd3}};

      rst = 1'b1; seed_vld = 1'b0; seed_data = '0; start = 1'b0;
      num = '0; stop = 1'b0; rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_vld", 64'(vld), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_data", 64'(data), 64'd1);
      rst = 1'b0;

      // Reset seed is 1 without any seed load
      go(1'b0, '0, 16'd2);
      expect_run("rst_seed", 2, 54'd1);

      for (int i = 0; i < 6; i++) begin
         go(vt[i].ld, vt[i].seed, vt[i].n);
         xf = 0; last = 0; dn = 1'b0;
         for (int c = 1; c <= 40 && !dn; c++) begin
            if (vld && rdy) begin
               if (xf < 4) chk($sformatf("vec%0d_d%0d", i, xf),
                               64'(data), 64'(vt[i].exp[xf]));
               xf++;
               last = c;
            end
            if (done) begin
               dn = 1'b1;
               chk($sformatf("vec%0d_dcyc", i), 64'(c),
                   64'(vt[i].n == 0 ? 1 : last + 1));
            end else @(negedge clk);
         end
         chk($sformatf("vec%0d_done", i), 64'(dn), 64'd1);
         chk($sformatf("vec%0d_n", i), 64'(xf), 64'(vt[i].n));
      end

      // Stall: data holds, seed/start during RUN ignored
      rdy = 1'b0;
      go(1'b1, 54'd1, 16'd2);
      for (int k = 0; k < 3; k++) begin
         chk("stall_vld", 64'(vld), 64'd1);
         chk("stall_data", 64'(data), 64'd1);
         seed_vld = 1'b1; seed_data = 54'd99;
         start = 1'b1; num = 16'd7;
         @(negedge clk);
      end
      seed_vld = 1'b0; start = 1'b0; rdy = 1'b1;
      expect_run("stall", 2, 54'd1);

      // Stop together with the fifth transfer
      go(1'b1, 54'd1, 16'd100);
      xf = 0;
      for (int c = 0; c < 30 && xf < 5; c++) begin
         if (vld && rdy) begin
            chk("stop_d", 64'(data), 64'(54'd1 << xf));
            xf++;
         end
         if (xf == 5) stop = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      stop = 1'b0;
      chk("stop_n", 64'(xf), 64'd5);
      chk("stop_done", 64'(done), 64'd1);
      chk("stop_busy", 64'(busy), 64'd0);
      chk("stop_vld", 64'(vld), 64'd0);
`ifdef LFSR_SEED_RESTORE_EN
      e2 = 54'd1;
`else
      e2 = 54'd32;
`endif
      go(1'b0, '0, 16'd1);
      expect_run("after_stop", 1, e2);

      // Two consecutive runs from seed 1
      go(1'b1, 54'd1, 16'd2);
      expect_run("run1", 2, 54'd1);
`ifdef LFSR_SEED_RESTORE_EN
      e2 = 54'd1;
`else
      e2 = 54'd4;
`endif
      go(1'b0, '0, 16'd2);
      expect_run("run2", 2, e2);

      // Asynchronous reset in the middle of a run
      go(1'b1, 54'd1, 16'd10);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mrst_vld", 64'(vld), 64'd0);
      chk("mrst_data", 64'(data), 64'd1);
      chk("mrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("mrst_nodone", 64'(done), 64'd0);
         chk("mrst_idle", 64'(vld), 64'd0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
